input_port_mc: RTL and testbench



---
 rtl/leaf_if_pkg.sv | 33 +++
 rtl/ip_reorder_buf.sv | 51 +++++
 rtl/input_port_mc.sv | 201 ++++++++++++++++++++
 tb/tb_input_port_mc.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_if_pkg.sv
// leaf_if_pkg: BFT leaf packet layout helpers and credit FSM state.
// Layout, MSB first: {vld, leaf, port, pad, addr, payload}.
package leaf_if_pkg;

    localparam int VLD_W          = 1;
    localparam int PAYLOAD_LO     = 0;
    localparam int CREDIT_PAYLOAD = 1;

    typedef enum logic {
        CR_IDLE = 1'b0,
        CR_SEND = 1'b1
    } cr_state_t;

    function automatic int vld_pos(input int packet_bits);
        return packet_bits - VLD_W;
    endfunction

    function automatic int leaf_lo(input int packet_bits,
                                   input int leaf_bits);
        return packet_bits - VLD_W - leaf_bits;
    endfunction

    function automatic int port_lo(input int packet_bits,
                                   input int leaf_bits,
                                   input int port_bits);
        return packet_bits - VLD_W - leaf_bits - port_bits;
    endfunction

    function automatic int addr_lo(input int payload_bits);
        return PAYLOAD_LO + payload_bits;
    endfunction

endpackage

// File: rtl/ip_reorder_buf.sv
// ip_reorder_buf: per-channel slot store drained strictly in address order.
// Overwrite detect port exists only with INPUT_PORT_MC_ERR_EN.
module ip_reorder_buf #(
    parameter int W  = 64,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_pop,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data
`ifdef INPUT_PORT_MC_ERR_EN
    ,
    output logic          overwrite
`endif
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    rd_ptr;

    assign rd_valid = valid[rd_ptr];
    assign rd_data  = mem[rd_ptr];

`ifdef INPUT_PORT_MC_ERR_EN
    assign overwrite = wr_en && valid[wr_addr];
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A same-edge write to the popped slot keeps the new word valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= '0;
            rd_ptr <= '0;
        end else begin
            if (rd_pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (wr_en) valid[wr_addr] <= 1'b1;
        end
    end

endmodule

// File: rtl/input_port_mc.sv
// input_port_mc: multi-channel BFT input port with reorder and credit return.
// Error flag logic is built only with INPUT_PORT_MC_ERR_EN defined.
module input_port_mc
    import leaf_if_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 64,
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS
                                  + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int NUM_CH        = 2,
    parameter int PORT_BASE     = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PACKET_BITS-1:0]       din_leaf_bft2interface,
    input  logic [NUM_LEAF_BITS-1:0]     src_leaf,
    output logic [NUM_CH*PAYLOAD_BITS-1:0] dout2user,
    output logic [NUM_CH-1:0]            vld2user,
    input  logic [NUM_CH-1:0]            ack_user2b_in,
    output logic [PACKET_BITS-1:0]       update_pkt,
    output logic                         update_vld,
    input  logic                         update_ack,
    output logic [1:0]                   err_flags
);
    localparam int VLD_POS = vld_pos(PACKET_BITS);
    localparam int LEAF_LO = leaf_lo(PACKET_BITS, NUM_LEAF_BITS);
    localparam int PORT_LO = port_lo(PACKET_BITS, NUM_LEAF_BITS,
                                     NUM_PORT_BITS);
    localparam int ADDR_LO = addr_lo(PAYLOAD_BITS);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W   = NUM_ADDR_BITS + 1;

    logic                     in_vld;
    logic [NUM_PORT_BITS-1:0] in_port;
    logic [NUM_ADDR_BITS-1:0] in_addr;
    logic [PAYLOAD_BITS-1:0]  in_data;
    logic                     unused_leaf;

    assign in_vld  = din_leaf_bft2interface[VLD_POS];
    assign in_port = din_leaf_bft2interface[PORT_LO +: NUM_PORT_BITS];
    assign in_addr = din_leaf_bft2interface[ADDR_LO +: NUM_ADDR_BITS];
    assign in_data = din_leaf_bft2interface[PAYLOAD_LO +: PAYLOAD_BITS];
    assign unused_leaf = ^din_leaf_bft2interface[VLD_POS-1:LEAF_LO];

    cr_state_t        cr_state;
    logic [CH_W-1:0]  cr_sel;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  pick;
    logic             any_pend;
    logic [NUM_CH-1:0] pend_nz;
    logic [NUM_CH-1:0] wr_hit;
    logic [PACKET_BITS-1:0] credit_pkt;

`ifdef INPUT_PORT_MC_ERR_EN
    logic [NUM_CH-1:0] ovw;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                    out_vld;
        logic [PAYLOAD_BITS-1:0] out_data;
        logic [CNT_W-1:0]        hs_cnt;
        logic [CNT_W-1:0]        pending;
        logic                    rd_valid;
        logic [PAYLOAD_BITS-1:0] rd_data;
        logic                    wr_en;
        logic                    rd_pop;
        logic                    hs;
        logic                    wrap;
        logic                    dec;

        assign wr_en  = in_vld
                        && (in_port == NUM_PORT_BITS'(PORT_BASE + c));
        assign rd_pop = rd_valid && (!out_vld || ack_user2b_in[c]);
        assign hs     = out_vld && ack_user2b_in[c];
        assign wrap   = hs && (hs_cnt
                        == CNT_W'(FREESPACE_UPDATE_SIZE - 1));
        assign dec    = (cr_state == CR_SEND) && update_ack
                        && (cr_sel == CH_W'(c));

        assign wr_hit[c]   = wr_en;
        assign pend_nz[c]  = |pending;
        assign vld2user[c] = out_vld;
        assign dout2user[c*PAYLOAD_BITS +: PAYLOAD_BITS] = out_data;

        ip_reorder_buf #(
            .W  (PAYLOAD_BITS),
            .AW (NUM_ADDR_BITS)
        ) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en    (wr_en),
            .wr_addr  (in_addr),
            .wr_data  (in_data),
            .rd_pop   (rd_pop),
            .rd_valid (rd_valid),
            .rd_data  (rd_data)
`ifdef INPUT_PORT_MC_ERR_EN
            ,
            .overwrite (ovw[c])
`endif
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_vld  <= 1'b0;
                out_data <= '0;
            end else if (rd_pop) begin
                out_vld  <= 1'b1;
                out_data <= rd_data;
            end else if (hs) begin
                out_vld  <= 1'b0;
            end
        end

        // Wrap and credit return on the same edge cancel out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hs_cnt  <= '0;
                pending <= '0;
            end else begin
                if (hs) hs_cnt <= wrap ? '0 : hs_cnt + 1'b1;
                if (wrap && !dec) pending <= pending + 1'b1;
                else if (!wrap && dec) pending <= pending - 1'b1;
            end
        end
    end

    // Round-robin: lowest offset from rr_ptr with credit pending wins.
    always_comb begin
        logic [CH_W:0] idx;
        any_pend = 1'b0;
        pick     = rr_ptr;
        idx      = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
            if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
            if (pend_nz[idx[CH_W-1:0]]) begin
                any_pend = 1'b1;
                pick     = idx[CH_W-1:0];
            end
        end
    end

    always_comb begin
        credit_pkt = '0;
        credit_pkt[VLD_POS] = 1'b1;
        credit_pkt[LEAF_LO +: NUM_LEAF_BITS] = src_leaf;
        credit_pkt[PORT_LO +: NUM_PORT_BITS] =
            NUM_PORT_BITS'(PORT_BASE) + NUM_PORT_BITS'(pick);
        credit_pkt[PAYLOAD_LO +: PAYLOAD_BITS] =
            PAYLOAD_BITS'(CREDIT_PAYLOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr_state   <= CR_IDLE;
            cr_sel     <= '0;
            rr_ptr     <= '0;
            update_vld <= 1'b0;
            update_pkt <= '0;
        end else begin
            unique case (cr_state)
                CR_IDLE: begin
                    if (any_pend) begin
                        cr_state   <= CR_SEND;
                        cr_sel     <= pick;
                        update_vld <= 1'b1;
                        update_pkt <= credit_pkt;
                    end
                end
                CR_SEND: begin
                    if (update_ack) begin
                        cr_state   <= CR_IDLE;
                        update_vld <= 1'b0;
                        update_pkt <= '0;
                        rr_ptr     <= (cr_sel == CH_W'(NUM_CH - 1))
                                      ? '0 : cr_sel + 1'b1;
                    end
                end
                default: cr_state <= CR_IDLE;
            endcase
        end
    end

`ifdef INPUT_PORT_MC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
        end else begin
            if (|ovw) err_flags[0] <= 1'b1;
            if (in_vld && !(|wr_hit)) err_flags[1] <= 1'b1;
        end
    end
`else
    assign err_flags = '0;
`endif

endmodule

// File: tb/tb_input_port_mc.sv
// tb_input_port_mc: directed + random stimulus for input_port_mc.
// Reference: per-channel expected word queues, handshake and credit tallies.
`timescale 1ns/1ps
module tb_input_port_mc;
    localparam int PW    = 64;
    localparam int LB    = 6;
    localparam int PB    = 4;
    localparam int AB    = 7;
    localparam int NCH   = 2;
    localparam int PBASE = 2;
    localparam int FSU   = 64;
    localparam int KB    = 1 + LB + PB + AB + PW;
    localparam int DEPTH = 1 << AB;
    localparam int PORT_LO = PW + AB;
    localparam int LEAF_LO = PW + AB + PB;
`ifdef INPUT_PORT_MC_ERR_EN
    localparam logic [1:0] ERR_EXP = 2'b11;
`else
    localparam logic [1:0] ERR_EXP = 2'b00;
`endif

    typedef logic [PW-1:0] word_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [KB-1:0]     din;
    logic [LB-1:0]     src_leaf;
    logic [NCH*PW-1:0] dout2user;
    logic [NCH-1:0]    vld2user;
    logic [NCH-1:0]    ack_user2b_in;
    logic [KB-1:0]     update_pkt;
    logic              update_vld;
    logic              update_ack;
    logic [1:0]        err_flags;

    always #5 clk = ~clk;

    input_port_mc dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .din_leaf_bft2interface (din),
        .src_leaf               (src_leaf),
        .dout2user              (dout2user),
        .vld2user               (vld2user),
        .ack_user2b_in          (ack_user2b_in),
        .update_pkt             (update_pkt),
        .update_vld             (update_vld),
        .update_ack             (update_ack),
        .err_flags              (err_flags)
    );

    int    checks = 0;
    int    errors = 0;
    word_t q0[$];
    word_t q1[$];
    int    seq[NCH];
    int    hs_n[NCH];
    int    cred_n[NCH];
    bit    rand_ack  = 1'b0;
    bit    rand_uack = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KB-1:0] pkt(input bit v, input int port,
                                          input int addr, input word_t d);
        logic [LB-1:0] lf;
        lf = LB'($urandom);
        return {v, lf, PB'(port), AB'(addr), d};
    endfunction

    function automatic word_t rnd_w();
        return {$urandom, $urandom};
    endfunction

    function automatic int qsize(input int ch);
        return (ch == 0) ? q0.size() : q1.size();
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ack)  ack_user2b_in = NCH'($urandom);
        if (rand_uack) update_ack = 1'($urandom);
    endtask

    task automatic idle();
        din = pkt(1'b0, $urandom, $urandom, rnd_w());
    endtask

    task automatic expect_w(input int ch, input word_t d);
        if (ch == 0) q0.push_back(d);
        else q1.push_back(d);
    endtask

    task automatic send(input int ch, input int addr, input word_t d);
        din = pkt(1'b1, PBASE + ch, addr % DEPTH, d);
    endtask

    task automatic stream(input int ch, input int n);
        word_t d;
        for (int i = 0; i < n; i++) begin
            d = rnd_w();
            expect_w(ch, d);
            send(ch, seq[ch], d);
            seq[ch]++;
            tick();
        end
        idle();
    endtask

    task automatic send_block(input int ch, input int k);
        word_t d[16];
        int    ord[16];
        int    j;
        int    t;
        for (int i = 0; i < k; i++) begin
            d[i] = rnd_w();
            expect_w(ch, d[i]);
            ord[i] = i;
        end
        for (int i = k - 1; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < k; i++) begin
            send(ch, seq[ch] + ord[i], d[ord[i]]);
            tick();
            if ($urandom_range(3, 0) == 0) begin
                idle();
                tick();
            end
        end
        seq[ch] += k;
        idle();
    endtask

    task automatic wait_room(input int ch, input int k);
        int n = 0;
        while (qsize(ch) + k > 100 && n < 2000) begin
            tick();
            n++;
        end
        chk("room wait", 1'(qsize(ch) + k <= 100), 1'b1);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q0.size() + q1.size()) > 0 && n < limit) begin
            tick();
            n++;
        end
        chk("drain left", q0.size() + q1.size(), 0);
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        for (int c = 0; c < NCH; c++) begin
            seq[c] = 0;
            hs_n[c] = 0;
            cred_n[c] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (vld2user[0] && ack_user2b_in[0]) begin
                hs_n[0]++;
                chk("ch0 expected", 1'(q0.size() > 0), 1'b1);
                if (q0.size() > 0) chk("ch0 data", dout2user[PW-1:0],
                                       q0.pop_front());
            end
            if (vld2user[1] && ack_user2b_in[1]) begin
                hs_n[1]++;
                chk("ch1 expected", 1'(q1.size() > 0), 1'b1);
                if (q1.size() > 0) chk("ch1 data", dout2user[2*PW-1:PW],
                                       q1.pop_front());
            end
            if (update_vld && update_ack) begin
                chk("credit payload", update_pkt[PW-1:0], 1);
                chk("credit hdr",
                    {update_pkt[KB-1], update_pkt[LEAF_LO +: LB],
                     update_pkt[PW +: AB]},
                    {1'b1, src_leaf, AB'(0)});
                if (update_pkt[PORT_LO +: PB] == PB'(PBASE))
                    cred_n[0]++;
                else if (update_pkt[PORT_LO +: PB] == PB'(PBASE + 1))
                    cred_n[1]++;
                else
                    chk("credit port", update_pkt[PORT_LO +: PB],
                        PB'(PBASE));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t d;
        int    n;
        int    s;
        rst_n = 1'b0;
        din = '0;
        src_leaf = 6'h2A;
        ack_user2b_in = '0;
        update_ack = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst vld2user", vld2user, 0);
        chk("rst dout2user", dout2user, 0);
        chk("rst update_vld", update_vld, 0);
        chk("rst update_pkt", update_pkt, 0);
        chk("rst err_flags", err_flags, 0);
        rst_n = 1'b1;
        ack_user2b_in = 2'b11;
        idle();
        tick();

        // In-order ch0: first word visible two edges after it is sent.
        for (int i = 0; i < 4; i++) begin
            expect_w(0, word_t'(8'hA0 + i));
            send(0, i, word_t'(8'hA0 + i));
            tick();
            if (i == 0) begin
                chk("inord latency", vld2user[0], 0);
            end else begin
                chk("inord vld", vld2user[0], 1);
                chk("inord data", dout2user[PW-1:0], 8'hA0 + i - 1);
            end
        end
        idle();
        tick();
        chk("inord vld3", vld2user[0], 1);
        chk("inord data3", dout2user[PW-1:0], 8'hA3);
        tick();
        chk("inord done", vld2user[0], 0);
        seq[0] = 4;

        // Reorder ch1: addresses 2,0,1 drain as 0,1,2.
        for (int i = 0; i < 3; i++) expect_w(1, word_t'(8'hB0 + i));
        send(1, 2, 64'hB2);
        tick();
        chk("reord hold a", vld2user[1], 0);
        send(1, 0, 64'hB0);
        tick();
        chk("reord hold b", vld2user[1], 0);
        send(1, 1, 64'hB1);
        tick();
        chk("reord first", dout2user[2*PW-1:PW], 64'hB0);
        idle();
        tick();
        chk("reord second", dout2user[2*PW-1:PW], 64'hB1);
        tick();
        chk("reord third", dout2user[2*PW-1:PW], 64'hB2);
        tick();
        chk("reord done", vld2user[1], 0);
        seq[1] = 3;

        // Wrap: 130 in-order words across address 127 -> 0.
        update_ack = 1'b1;
        stream(0, 130);
        drain(50);
        chk("wrap err_flags", err_flags, 0);

        // Random shuffled blocks with random backpressure.
        rand_ack = 1'b1;
        rand_uack = 1'b1;
        for (int b = 0; b < 24; b++) begin
            n = int'($urandom_range(1, 0));
            s = int'($urandom_range(12, 1));
            wait_room(n, s);
            send_block(n, s);
        end
        rand_ack = 1'b0;
        rand_uack = 1'b0;
        ack_user2b_in = 2'b11;
        update_ack = 1'b1;
        drain(600);
        repeat (20) tick();
        chk("rand credits ch0", cred_n[0], hs_n[0] / FSU);
        chk("rand credits ch1", cred_n[1], hs_n[1] / FSU);
        chk("rand err_flags", err_flags, 0);

        rst_n = 1'b0;
        clear_model();
        tick();
        rst_n = 1'b1;
        update_ack = 1'b0;
        tick();

        // Credit: both channels reach 64 handshakes, ack held off.
        stream(0, 64);
        stream(1, 64);
        drain(50);
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("cred0 vld", update_vld, 1);
            chk("cred0 port", update_pkt[PORT_LO +: PB], PBASE);
            chk("cred0 payload", update_pkt[PW-1:0], 1);
            tick();
        end
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
        n = 0;
        while (!update_vld && n < 6) begin
            tick();
            n++;
        end
        chk("cred1 vld", update_vld, 1);
        chk("cred1 port", update_pkt[PORT_LO +: PB], PBASE + 1);
        chk("cred1 payload", update_pkt[PW-1:0], 1);
        update_ack = 1'b1;
        tick();
        update_ack = 1'b0;
        repeat (4) tick();
        chk("cred idle", update_vld, 0);
        chk("cred count ch0", cred_n[0], 1);
        chk("cred count ch1", cred_n[1], 1);

        // Errors, then asynchronous reset while busy.
        stream(0, 64);
        drain(50);
        repeat (3) tick();
        ack_user2b_in = 2'b01;
        stream(1, 2);
        s = (seq[0] + 5) % DEPTH;
        send(0, s, rnd_w());
        tick();
        send(0, s, rnd_w());
        tick();
        din = pkt(1'b1, 9, 0, rnd_w());
        tick();
        idle();
        tick();
        chk("err flags", err_flags, ERR_EXP);
        repeat (3) tick();
        chk("err sticky", err_flags, ERR_EXP);
        chk("busy update_vld", update_vld, 1);
        chk("busy vld2user1", vld2user[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst vld2user", vld2user, 0);
        chk("arst dout2user", dout2user, 0);
        chk("arst update_vld", update_vld, 0);
        chk("arst update_pkt", update_pkt, 0);
        chk("arst err_flags", err_flags, 0);
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;
        ack_user2b_in = 2'b11;
        d = rnd_w();
        expect_w(0, d);
        send(0, 0, d);
        seq[0] = 1;
        tick();
        chk("fresh latency", vld2user[0], 0);
        idle();
        tick();
        chk("fresh vld", vld2user[0], 1);
        chk("fresh data", dout2user[PW-1:0], d);
        repeat (5) tick();
        chk("no replay", update_vld, 0);
        chk("fresh drained", q0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
